// File: rtl/tomasulo_pkg.sv
// Shared types and constants for the Tomasulo reorder buffer and register alias table.
package tomasulo_pkg;

    localparam int DEF_ROB_DEPTH     = 8;
    localparam int DEF_NUM_CDB       = 3;
    localparam int DEF_COMMIT_WIDTH  = 2;
    localparam int DEF_NUM_REGISTERS = 8;
    localparam int DEF_ID_W          = 5;
    localparam int DEF_TAG_W         = $clog2(DEF_ROB_DEPTH);
    localparam int DEF_REG_W         = $clog2(DEF_NUM_REGISTERS);

    localparam logic [2:0] LOAD = 3'b001;
    localparam logic [2:0] ADD  = 3'b010;
    localparam logic [2:0] SUB  = 3'b011;
    localparam logic [2:0] MUL  = 3'b100;
    localparam logic [2:0] DIV  = 3'b101;

    // Execution latencies in cycles for the functional unit classes feeding the CDB.
    localparam int LAT_LOAD = 2;
    localparam int LAT_ADD  = 1;
    localparam int LAT_SUB  = 1;
    localparam int LAT_MUL  = 3;
    localparam int LAT_DIV  = 8;

    typedef struct packed {
        logic                 valid;
        logic                 done;
        logic [DEF_REG_W-1:0] dst;
        logic [DEF_ID_W-1:0]  id;
    } rob_entry_t;

    typedef struct packed {
        logic                 busy;
        logic [DEF_TAG_W-1:0] tag;
    } rat_entry_t;

endpackage

// File: rtl/tomasulo_rat.sv
// Register alias table: maps each architectural register to its youngest in-flight producer tag.
module tomasulo_rat
    import tomasulo_pkg::*;
#(
    parameter int NUM_REGISTERS = DEF_NUM_REGISTERS,
    parameter int REG_W         = $clog2(NUM_REGISTERS),
    parameter int TAG_W         = DEF_TAG_W,
    parameter int COMMIT_WIDTH  = DEF_COMMIT_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          flush,
    input  logic [REG_W-1:0]              src1_reg,
    input  logic [REG_W-1:0]              src2_reg,
    output logic                          src1_busy,
    output logic [TAG_W-1:0]              src1_tag,
    output logic                          src2_busy,
    output logic [TAG_W-1:0]              src2_tag,
    input  logic                          alloc_we,
    input  logic [REG_W-1:0]              alloc_reg,
    input  logic [TAG_W-1:0]              alloc_tag,
    input  logic [COMMIT_WIDTH-1:0]       commit_valid,
    input  logic [COMMIT_WIDTH*REG_W-1:0] commit_dst,
    input  logic [COMMIT_WIDTH*TAG_W-1:0] commit_tag
);

    logic [NUM_REGISTERS-1:0] busy_q, busy_d;
    logic [TAG_W-1:0]         tag_q [NUM_REGISTERS];
    logic [TAG_W-1:0]         tag_d [NUM_REGISTERS];

    assign src1_busy = busy_q[src1_reg];
    assign src1_tag  = tag_q[src1_reg];
    assign src2_busy = busy_q[src2_reg];
    assign src2_tag  = tag_q[src2_reg];

    // Next-state: retiring producers release their register, then a new allocation claims it.
    always_comb begin
        busy_d = busy_q;
        tag_d  = tag_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            for (int i = 0; i < COMMIT_WIDTH; i++) begin
                busy_d[commit_dst[i*REG_W +: REG_W]] = busy_d[commit_dst[i*REG_W +: REG_W]] &
                    ~(commit_valid[i] &
                      (tag_q[commit_dst[i*REG_W +: REG_W]] == commit_tag[i*TAG_W +: TAG_W]));
            end
            // Applied last so a same-cycle allocation to a retiring dst keeps it busy.
            busy_d[alloc_reg] = busy_d[alloc_reg] | alloc_we;
            tag_d[alloc_reg]  = alloc_we ? alloc_tag : tag_q[alloc_reg];
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
            for (int r = 0; r < NUM_REGISTERS; r++) begin
                tag_q[r] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            tag_q  <= tag_d;
        end
    end

endmodule

// File: rtl/tomasulo_rob.sv
// Reorder buffer with CDB write-back, multi-wide in-order commit and an attached RAT.
module tomasulo_rob
    import tomasulo_pkg::*;
#(
    parameter int ROB_DEPTH     = DEF_ROB_DEPTH,
    parameter int TAG_W         = $clog2(ROB_DEPTH),
    parameter int NUM_CDB       = DEF_NUM_CDB,
    parameter int COMMIT_WIDTH  = DEF_COMMIT_WIDTH,
    parameter int NUM_REGISTERS = DEF_NUM_REGISTERS,
    parameter int REG_W         = $clog2(NUM_REGISTERS),
    parameter int ID_W          = DEF_ID_W
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          flush,
    input  logic                          alloc_valid,
    output logic                          alloc_ready,
    input  logic [REG_W-1:0]              alloc_dst,
    input  logic [ID_W-1:0]               alloc_id,
    output logic [TAG_W-1:0]              alloc_tag,
    input  logic [REG_W-1:0]              src1_reg,
    input  logic [REG_W-1:0]              src2_reg,
    output logic                          src1_busy,
    output logic                          src2_busy,
    output logic [TAG_W-1:0]              src1_tag,
    output logic [TAG_W-1:0]              src2_tag,
    output logic                          src1_ready,
    output logic                          src2_ready,
    input  logic [NUM_CDB-1:0]            cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]      cdb_tag,
    output logic [COMMIT_WIDTH-1:0]       commit_valid,
    output logic [COMMIT_WIDTH*ID_W-1:0]  commit_id,
    output logic [COMMIT_WIDTH*REG_W-1:0] commit_dst,
    output logic [TAG_W:0]                count,
    output logic                          empty,
    output logic                          full
);

    localparam logic [TAG_W:0] DEPTH_CNT = (TAG_W+1)'(ROB_DEPTH);

    logic [TAG_W-1:0]              head_q, head_d, tail_q, tail_d;
    logic [TAG_W:0]                count_q, count_d;
    logic [ROB_DEPTH-1:0]          valid_q, valid_d, done_q, done_d;
    logic [REG_W-1:0]              dst_q [ROB_DEPTH];
    logic [REG_W-1:0]              dst_d [ROB_DEPTH];
    logic [ID_W-1:0]               id_q [ROB_DEPTH];
    logic [ID_W-1:0]               id_d [ROB_DEPTH];
    logic [COMMIT_WIDTH-1:0]       commit_valid_q, commit_valid_d;
    logic [COMMIT_WIDTH*ID_W-1:0]  commit_id_q, commit_id_d;
    logic [COMMIT_WIDTH*REG_W-1:0] commit_dst_q, commit_dst_d;

    logic                          alloc_fire_s;
    logic [COMMIT_WIDTH-1:0]       retire_s;
    logic [TAG_W:0]                retire_n_s;
    logic [COMMIT_WIDTH*TAG_W-1:0] retire_tag_s;
    logic [COMMIT_WIDTH*REG_W-1:0] retire_dst_s;
    logic                          src1_busy_s, src2_busy_s;
    logic [TAG_W-1:0]              src1_tag_s, src2_tag_s;

    function automatic logic cdb_hit(input logic [TAG_W-1:0]         t,
                                     input logic [NUM_CDB-1:0]       v,
                                     input logic [NUM_CDB*TAG_W-1:0] tags);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NUM_CDB; k++) begin
            hit = hit | (v[k] & (tags[k*TAG_W +: TAG_W] == t));
        end
        return hit;
    endfunction

    assign alloc_ready  = (count_q != DEPTH_CNT) & ~flush;
    assign alloc_fire_s = alloc_valid & alloc_ready;
    assign alloc_tag    = tail_q;
    assign count        = count_q;
    assign empty        = (count_q == '0);
    assign full         = (count_q == DEPTH_CNT);
    assign commit_valid = commit_valid_q;
    assign commit_id    = commit_id_q;
    assign commit_dst   = commit_dst_q;

    assign src1_busy  = src1_busy_s;
    assign src2_busy  = src2_busy_s;
    assign src1_tag   = src1_tag_s;
    assign src2_tag   = src2_tag_s;
    assign src1_ready = src1_busy_s & (done_q[src1_tag_s] | cdb_hit(src1_tag_s, cdb_valid, cdb_tag));
    assign src2_ready = src2_busy_s & (done_q[src2_tag_s] | cdb_hit(src2_tag_s, cdb_valid, cdb_tag));

    // Longest run of valid+done entries from head, capped at the commit width.
    always_comb begin : retire_select
        logic             run;
        logic [TAG_W-1:0] idx;
        run          = 1'b1;
        retire_s     = '0;
        retire_n_s   = '0;
        retire_tag_s = '0;
        retire_dst_s = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            idx = head_q + TAG_W'(i);
            retire_tag_s[i*TAG_W +: TAG_W] = idx;
            retire_dst_s[i*REG_W +: REG_W] = dst_q[idx];
            if (run && valid_q[idx] && done_q[idx]) begin
                retire_s[i] = 1'b1;
                retire_n_s  = retire_n_s + (TAG_W+1)'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

    // Next-state for entries, pointers and the registered commit trace.
    always_comb begin
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        valid_d        = valid_q;
        done_d         = done_q;
        dst_d          = dst_q;
        id_d           = id_q;
        commit_valid_d = '0;
        commit_id_d    = '0;
        commit_dst_d   = '0;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            valid_d = '0;
            done_d  = '0;
        end else begin
            for (int k = 0; k < NUM_CDB; k++) begin
                done_d[cdb_tag[k*TAG_W +: TAG_W]] = done_d[cdb_tag[k*TAG_W +: TAG_W]] |
                    (cdb_valid[k] & valid_q[cdb_tag[k*TAG_W +: TAG_W]]);
            end
            for (int i = 0; i < COMMIT_WIDTH; i++) begin
                if (retire_s[i]) begin
                    valid_d[retire_tag_s[i*TAG_W +: TAG_W]] = 1'b0;
                    done_d[retire_tag_s[i*TAG_W +: TAG_W]]  = 1'b0;
                    commit_id_d[i*ID_W +: ID_W]    = id_q[retire_tag_s[i*TAG_W +: TAG_W]];
                    commit_dst_d[i*REG_W +: REG_W] = retire_dst_s[i*REG_W +: REG_W];
                end else begin
                    commit_id_d[i*ID_W +: ID_W]    = '0;
                    commit_dst_d[i*REG_W +: REG_W] = '0;
                end
            end
            commit_valid_d  = retire_s;
            valid_d[tail_q] = valid_d[tail_q] | alloc_fire_s;
            done_d[tail_q]  = done_d[tail_q] & ~alloc_fire_s;
            dst_d[tail_q]   = alloc_fire_s ? alloc_dst : dst_q[tail_q];
            id_d[tail_q]    = alloc_fire_s ? alloc_id : id_q[tail_q];
            head_d  = head_q + retire_n_s[TAG_W-1:0];
            tail_d  = tail_q + TAG_W'(alloc_fire_s);
            count_d = count_q + (TAG_W+1)'(alloc_fire_s) - retire_n_s;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            valid_q        <= '0;
            done_q         <= '0;
            commit_valid_q <= '0;
            commit_id_q    <= '0;
            commit_dst_q   <= '0;
            for (int e = 0; e < ROB_DEPTH; e++) begin
                dst_q[e] <= '0;
                id_q[e]  <= '0;
            end
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            valid_q        <= valid_d;
            done_q         <= done_d;
            commit_valid_q <= commit_valid_d;
            commit_id_q    <= commit_id_d;
            commit_dst_q   <= commit_dst_d;
            dst_q          <= dst_d;
            id_q           <= id_d;
        end
    end

    tomasulo_rat #(
        .NUM_REGISTERS (NUM_REGISTERS),
        .REG_W         (REG_W),
        .TAG_W         (TAG_W),
        .COMMIT_WIDTH  (COMMIT_WIDTH)
    ) u_rat (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush        (flush),
        .src1_reg     (src1_reg),
        .src2_reg     (src2_reg),
        .src1_busy    (src1_busy_s),
        .src1_tag     (src1_tag_s),
        .src2_busy    (src2_busy_s),
        .src2_tag     (src2_tag_s),
        .alloc_we     (alloc_fire_s),
        .alloc_reg    (alloc_dst),
        .alloc_tag    (tail_q),
        .commit_valid (retire_s),
        .commit_dst   (retire_dst_s),
        .commit_tag   (retire_tag_s)
    );

endmodule

// File: tb/tb_tomasulo_rob.sv
// Directed bench for tomasulo_rob: queue-based reference model checked every cycle plus literal pins.
module tb_tomasulo_rob;
    import tomasulo_pkg::*;

    localparam int DEPTH = 8, TW = 3, NCDB = 3, CW = 2, NREG = 8, RW = 3, IW = 5;

    logic            clk, reset_n, flush, alloc_valid, alloc_ready;
    logic [RW-1:0]   alloc_dst, src1_reg, src2_reg;
    logic [IW-1:0]   alloc_id;
    logic [TW-1:0]   alloc_tag, src1_tag, src2_tag;
    logic            src1_busy, src2_busy, src1_ready, src2_ready;
    logic [NCDB-1:0] cdb_valid;
    logic [NCDB*TW-1:0] cdb_tag;
    logic [CW-1:0]   commit_valid;
    logic [CW*IW-1:0] commit_id;
    logic [CW*RW-1:0] commit_dst;
    logic [TW:0]     count;
    logic            empty, full;

    tomasulo_rob #(.ROB_DEPTH(DEPTH), .NUM_CDB(NCDB), .COMMIT_WIDTH(CW),
                   .NUM_REGISTERS(NREG), .ID_W(IW)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_dst(alloc_dst),
        .alloc_id(alloc_id), .alloc_tag(alloc_tag),
        .src1_reg(src1_reg), .src2_reg(src2_reg), .src1_busy(src1_busy), .src2_busy(src2_busy),
        .src1_tag(src1_tag), .src2_tag(src2_tag), .src1_ready(src1_ready), .src2_ready(src2_ready),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .commit_valid(commit_valid), .commit_id(commit_id), .commit_dst(commit_dst),
        .count(count), .empty(empty), .full(full));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: program-order queue of in-flight entries plus a register map.
    typedef struct { rob_entry_t e; int tag; } m_ent_t;
    m_ent_t     mq[$];
    rat_entry_t mrat[NREG];
    int         mtail = 0;
    int         m_ncommit = 0;
    int         m_cid[CW];
    int         m_cdst[CW];

    function automatic void model_clear();
        mq.delete();
        for (int r = 0; r < NREG; r++) mrat[r] = '0;
        mtail = 0;
        m_ncommit = 0;
        for (int i = 0; i < CW; i++) begin m_cid[i] = 0; m_cdst[i] = 0; end
    endfunction

    initial model_clear();

    always @(posedge clk or negedge reset_n) begin : model
        int n, r;
        bit fire;
        m_ent_t t;
        if (!reset_n) begin
            model_clear();
        end else if (flush) begin
            model_clear();
        end else begin
            fire = alloc_valid && (mq.size() < DEPTH);
            n = 0;
            while (n < CW && n < mq.size() && mq[n].e.done) n++;
            m_ncommit = n;
            for (int i = 0; i < CW; i++) begin m_cid[i] = 0; m_cdst[i] = 0; end
            for (int i = 0; i < n; i++) begin
                m_cid[i]  = int'(mq[0].e.id);
                m_cdst[i] = int'(mq[0].e.dst);
                r = int'(mq[0].e.dst);
                if (mrat[r].busy && int'(mrat[r].tag) == mq[0].tag && !(fire && int'(alloc_dst) == r))
                    mrat[r].busy = 1'b0;
                void'(mq.pop_front());
            end
            for (int k = 0; k < NCDB; k++) begin
                for (int j = 0; j < mq.size(); j++) begin
                    if (cdb_valid[k] && mq[j].tag == int'(cdb_tag[k*TW +: TW])) begin
                        t = mq[j];
                        t.e.done = 1'b1;
                        mq[j] = t;
                    end
                end
            end
            if (fire) begin
                t.e.valid = 1'b1;
                t.e.done  = 1'b0;
                t.e.dst   = alloc_dst;
                t.e.id    = alloc_id;
                t.tag     = mtail;
                mq.push_back(t);
                mrat[alloc_dst] = '{busy: 1'b1, tag: TW'(mtail)};
                mtail = (mtail + 1) % DEPTH;
            end
        end
    end

    function automatic void model_lookup(input int r, output bit busy, output int tag, output bit rdy);
        busy = mrat[r].busy;
        tag  = int'(mrat[r].tag);
        rdy  = 1'b0;
        if (busy) begin
            foreach (mq[j]) if (mq[j].tag == tag && mq[j].e.done) rdy = 1'b1;
            for (int k = 0; k < NCDB; k++)
                if (cdb_valid[k] && int'(cdb_tag[k*TW +: TW]) == tag) rdy = 1'b1;
        end
    endfunction

    // Every-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clk) begin : compare
        bit b; int tg; bit rd;
        chk("count", count, mq.size());
        chk("empty", empty, mq.size() == 0);
        chk("full", full, mq.size() == DEPTH);
        chk("alloc_ready", alloc_ready, (mq.size() < DEPTH) && !flush);
        chk("alloc_tag", alloc_tag, mtail);
        chk("commit_valid", commit_valid, (32'd1 << m_ncommit) - 32'd1);
        for (int i = 0; i < m_ncommit; i++) begin
            chk("commit_id", commit_id[i*IW +: IW], m_cid[i]);
            chk("commit_dst", commit_dst[i*RW +: RW], m_cdst[i]);
        end
        model_lookup(int'(src1_reg), b, tg, rd);
        chk("src1_busy", src1_busy, b);
        if (b) chk("src1_tag", src1_tag, tg);
        chk("src1_ready", src1_ready, rd);
        model_lookup(int'(src2_reg), b, tg, rd);
        chk("src2_busy", src2_busy, b);
        if (b) chk("src2_tag", src2_tag, tg);
        chk("src2_ready", src2_ready, rd);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc(input int id, input int dst);
        alloc_valid = 1'b1;
        alloc_id    = IW'(id);
        alloc_dst   = RW'(dst);
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic cdb1(input int tag);
        cdb_valid = 3'b001;
        cdb_tag   = {6'd0, TW'(tag)};
        tick();
        cdb_valid = 3'b000;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; alloc_valid = 1'b0; alloc_dst = '0; alloc_id = '0;
        src1_reg = '0; src2_reg = '0; cdb_valid = '0; cdb_tag = '0;
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        #1;
        chk("rst_alloc_ready", alloc_ready, 1);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_commit_valid", commit_valid, 0);
        tick();

        // Fill to capacity, then an ignored ninth request.
        for (int i = 0; i < 8; i++) alloc(i, (i + 1) % 8);
        chk("t1_full", full, 1);
        chk("t1_alloc_ready", alloc_ready, 0);
        chk("t1_count", count, 8);
        alloc(8, 0);
        chk("t1_count_after_9th", count, 8);
        cdb_valid = 3'b111; cdb_tag = {3'd2, 3'd1, 3'd0}; tick();
        cdb_valid = 3'b111; cdb_tag = {3'd5, 3'd4, 3'd3}; tick();
        cdb_valid = 3'b111; cdb_tag = {3'd7, 3'd7, 3'd6}; tick();
        cdb_valid = 3'b000;
        repeat (6) tick();
        chk("t1_drained", empty, 1);

        // Out-of-order completion, in-order two-wide retirement.
        do_flush();
        alloc(0, 1); alloc(1, 2); alloc(2, 3);
        cdb1(2); chk("t2_no_commit_a", commit_valid, 0);
        cdb1(1); chk("t2_no_commit_b", commit_valid, 0);
        cdb1(0); chk("t2_no_commit_c", commit_valid, 0);
        tick();
        chk("t2_cv_11", commit_valid, 2'b11);
        chk("t2_id0", commit_id[4:0], 0);
        chk("t2_id1", commit_id[9:5], 1);
        tick();
        chk("t2_cv_01", commit_valid, 2'b01);
        chk("t2_id2", commit_id[4:0], 2);
        tick();

        // CDB bypass on operand lookup.
        do_flush();
        alloc(0, 3);
        src1_reg = 3'd3; cdb_valid = 3'b001; cdb_tag = 9'd0;
        #1;
        chk("t3_busy", src1_busy, 1);
        chk("t3_tag", src1_tag, 0);
        chk("t3_bypass_ready", src1_ready, 1);
        cdb_valid = 3'b000; #1;
        chk("t3_not_ready", src1_ready, 0);
        cdb_valid = 3'b001;
        tick();
        cdb_valid = 3'b000; #1;
        chk("t3_done_ready", src1_ready, 1);
        tick();
        chk("t3_released", src1_busy, 0);

        // Same-cycle allocation to a retiring destination keeps the register busy.
        do_flush();
        alloc(0, 5);
        cdb1(0);
        src1_reg = 3'd5;
        alloc(1, 5);
        chk("t4_busy", src1_busy, 1);
        chk("t4_tag", src1_tag, 1);
        chk("t4_cv", commit_valid, 2'b01);
        chk("t4_id", commit_id[4:0], 0);
        cdb1(1);
        repeat (2) tick();
        chk("t4_released", src1_busy, 0);

        // Wrap-around over twenty single allocate/complete pairs.
        do_flush();
        for (int i = 0; i < 20; i++) begin
            chk("t5_tag", alloc_tag, i % 8);
            alloc(i, i % 8);
            cdb1(i % 8);
            tick();
            chk("t5_cv", commit_valid, 1);
            chk("t5_id", commit_id[4:0], i);
        end
        chk("t5_empty", empty, 1);

        // Flush with five entries in flight, including an ignored strobe to an empty slot.
        do_flush();
        for (int i = 0; i < 5; i++) alloc(10 + i, i);
        cdb_valid = 3'b011; cdb_tag = {3'd0, 3'd7, 3'd1}; tick();
        cdb_valid = 3'b000;
        flush = 1'b1; #1;
        chk("t6_ready_during_flush", alloc_ready, 0);
        tick();
        flush = 1'b0; #1;
        chk("t6_count", count, 0);
        chk("t6_alloc_ready", alloc_ready, 1);
        chk("t6_commit_valid", commit_valid, 0);
        for (int r = 0; r < NREG; r++) begin
            src1_reg = RW'(r); #1;
            chk("t6_rat_busy", src1_busy, 0);
        end

        // Asynchronous reset mid-stream discards pending retirements.
        tick();
        alloc(20, 6); alloc(21, 7);
        cdb1(0);
        reset_n = 1'b0; #1;
        chk("t7_count", count, 0);
        chk("t7_commit_valid", commit_valid, 0);
        chk("t7_empty", empty, 1);
        @(posedge clk);
        #3 reset_n = 1'b1;
        tick();
        chk("t7_no_commit", commit_valid, 0);
        chk("t7_alloc_ready", alloc_ready, 1);
        src1_reg = 3'd6; #1;
        chk("t7_rat_clear", src1_busy, 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tomasulo_rob.md
Name: tomasulo_rob

Overview:
- Parametrised reorder buffer plus register alias table (RAT) for the next-generation Tomasulo core.
- Adds capabilities the current core lacks: configurable depth, N result-bus (CDB) ports, multi-wide in-order commit, full/empty back-pressure and flush.
- Sits between issue logic (allocation, operand lookup) and the functional units (CDB write-back).
- Reservation stations get operand tags from it; the commit status outputs drive the per-instruction commit trace.

Parameters:
- ROB_DEPTH, 8, number of ROB entries; power of two, >= 2.
- TAG_W, $clog2(ROB_DEPTH), width of an entry tag.
- NUM_CDB, 3, number of result-bus ports (one per FU class: mem, add, mul).
- COMMIT_WIDTH, 2, maximum entries retired per cycle.
- NUM_REGISTERS, 8, architectural registers.
- REG_W, $clog2(NUM_REGISTERS), register index width.
- ID_W, 5, width of the instruction sequence id carried for tracing.

Ports:
- clk  in  1  clock; all state is updated on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all entries and the RAT.
- alloc_valid  in  1  issue requests one entry.
- alloc_ready  out  1  asserted when count < ROB_DEPTH and flush = 0.
- alloc_dst  in  REG_W  destination register of the issuing instruction.
- alloc_id  in  ID_W  sequence id of the issuing instruction.
- alloc_tag  out  TAG_W  tag assigned to the allocation; equals the tail pointer.
- src1_reg, src2_reg  in  REG_W  operand registers to look up.
- src1_busy, src2_busy  out  1  operand has an uncommitted producer.
- src1_tag, src2_tag  out  TAG_W  producer tag; valid when busy.
- src1_ready, src2_ready  out  1  producer has already written back, or is on the CDB this cycle.
- cdb_valid  in  NUM_CDB  per-port write-back strobe.
- cdb_tag  in  NUM_CDB*TAG_W  per-port tag; port k occupies bits [k*TAG_W +: TAG_W].
- commit_valid  out  COMMIT_WIDTH  registered retire strobes; a thermometer code from bit 0.
- commit_id  out  COMMIT_WIDTH*ID_W  sequence ids of the retiring entries.
- commit_dst  out  COMMIT_WIDTH*REG_W  destination registers of the retiring entries.
- count  out  TAG_W+1  occupied entries.
- empty  out  1  count == 0.
- full  out  1  count == ROB_DEPTH.

Behaviour:
- Reset (reset_n low, asynchronous):
  - head = tail = count = 0; all entry valid/done bits = 0; all RAT busy bits = 0.
  - commit_valid = 0, commit_id = 0, commit_dst = 0.
  - Resulting outputs: alloc_ready = 1, empty = 1, full = 0.
  - Reset mid-operation discards all in-flight entries with no commit pulses.
- Allocation:
  - Occurs on an edge where alloc_valid && alloc_ready.
  - Entry[tail] gets valid = 1, done = 0, and stores dst and id.
  - tail increments, wrapping ROB_DEPTH-1 -> 0.
  - RAT[alloc_dst] gets busy = 1 and tag = tail.
- Back-pressure:
  - alloc_ready depends only on the registered count and flush.
  - When full, a same-cycle commit does not enable allocation; the freed slot is usable next cycle.
- Write-back:
  - For each port k with cdb_valid[k] and entry[cdb_tag_k] valid, done is set at the edge.
  - Strobes to invalid entries are ignored.
  - Duplicate tags across ports are ORed.
- Operand lookup (combinational):
  - busy and tag come from RAT[srcN_reg].
  - ready = done[tag] OR any cdb_valid[k] with cdb_tag_k == tag (CDB bypass).
  - When busy = 0, ready is don't-care and is driven 0.
- Commit:
  - Each cycle, find the largest n <= COMMIT_WIDTH such that entries head .. head+n-1 are all valid and done. Entries marked done at this edge are not counted.
  - At the edge those entries clear, head advances by n (mod ROB_DEPTH), and commit_valid[n-1:0] = 1 with id and dst in slot order.
  - Commit is strictly in order; a not-done entry blocks all younger entries.
  - RAT[dst] busy clears only if RAT[dst].tag equals the retiring tag and no same-cycle allocation targets that dst.
  - Same-cycle allocation to the same dst wins over the commit clear.
  - Two retirements in one cycle to the same dst: only the RAT tag match matters.
- Count: count_next = count + alloc_fire - n.
- Flush:
  - Has priority over allocation, write-back and commit.
  - Next state equals the reset state, except that the clear is synchronous.
  - commit_valid = 0 in the cycle after flush.
- Latency:
  - Allocation to earliest commit_valid pulse is 3 edges: allocate at edge 0, CDB at edge 1, retire registered at edge 2, visible after edge 2.

Decomposition:
- Shared package tomasulo_pkg holds:
  - opcode localparams (LOAD=3'b001, ADD, SUB, MUL, DIV) and unit latencies;
  - a rob_entry_t struct {valid, done, dst, id};
  - a rat_entry_t struct {busy, tag}.
- One natural sub-module, tomasulo_rat: register alias table with lookup, allocation write and commit clear, including the alloc-over-commit priority.

Test Plan:
- Reset, then allocate 8 entries (ids 0-7, dst r1..r8 mod 8) with no CDB. Required: full = 1, alloc_ready = 0 after the 8th edge; a 9th alloc_valid is ignored and count stays 8.
- Allocate tags 0,1,2; CDB tag 2, then 1, then 0 on successive cycles. Required: no commit until tag 0 is done, then commit_valid = 2'b11 (ids 0,1), then 2'b01 (id 2).
- Allocate id 0 to r3, then look up r3 while cdb_tag = 0 is valid the same cycle. Required: src1_busy = 1, src1_tag = 0, src1_ready = 1 (bypass).
- Allocate id 0 to r5, then id 1 to r5 in the cycle that id 0 retires. Required: RAT r5 stays busy with tag 1.
- Wrap-around: run 20 single allocate/complete pairs with DEPTH = 8. Required: tags cycle 0..7,0..; commit ids in order 0..19; empty = 1 at the end.
- Flush with 5 entries in flight, or deassert reset_n mid-stream. Required: count = 0, all RAT busy = 0, commit_valid = 0, alloc_ready = 1 on the next cycle.
